// File: rtl/noc_pkg.sv
// Shared types and head-flit helpers for the mesh network interface.
// The helpers are sized by the DEF_* widths below.
package noc_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_X_W    = 2;
    localparam int DEF_Y_W    = 1;
    localparam int FLIT_W     = DEF_DATA_W + 2;

    typedef enum logic [1:0] {
        FLIT_INVALID = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_e;

    typedef enum logic {T_IDLE, T_BODY} tx_state_e;
    typedef enum logic {R_HEAD, R_PAY}  rx_state_e;

    // The first field is the MSB, so dst_x lands in the lowest payload bits.
    typedef struct packed {
        logic [DEF_Y_W-1:0] src_y;
        logic [DEF_X_W-1:0] src_x;
        logic [DEF_Y_W-1:0] dst_y;
        logic [DEF_X_W-1:0] dst_x;
    } head_t;

    function automatic logic [DEF_DATA_W-1:0] pack_head(input head_t h);
        logic [DEF_DATA_W-1:0] p;
        p = '0;
        p[$bits(head_t)-1:0] = h;
        return p;
    endfunction

    function automatic head_t unpack_head(input logic [DEF_DATA_W-1:0] p);
        return head_t'(p[$bits(head_t)-1:0]);
    endfunction

endpackage

// File: rtl/noc_net_iface_if.sv
// Bundles the local TX/RX handshakes and the two mesh-side flit channels.
// The slave modport is the network interface's view of the bundle.
interface noc_net_iface_if #(
    parameter int DATA_W = noc_pkg::DEF_DATA_W,
    parameter int X_W    = noc_pkg::DEF_X_W,
    parameter int Y_W    = noc_pkg::DEF_Y_W
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [X_W-1:0]    tx_dst_x;
    logic [Y_W-1:0]    tx_dst_y;
    logic              tx_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W+1:0] out_flit;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W+1:0] in_flit;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic [X_W-1:0]    rx_src_x;
    logic [Y_W-1:0]    rx_src_y;
    logic              rx_last;
    logic [7:0]        err_cnt;

    modport master (
        output tx_valid, tx_data, tx_dst_x, tx_dst_y, tx_last, out_ready,
               in_valid, in_flit, rx_ready,
        input  tx_ready, out_valid, out_flit, in_ready, rx_valid, rx_data,
               rx_src_x, rx_src_y, rx_last, err_cnt
    );

    modport slave (
        input  tx_valid, tx_data, tx_dst_x, tx_dst_y, tx_last, out_ready,
               in_valid, in_flit, rx_ready,
        output tx_ready, out_valid, out_flit, in_ready, rx_valid, rx_data,
               rx_src_x, rx_src_y, rx_last, err_cnt
    );
endinterface

// File: rtl/noc_fifo.sv
// Small synchronous FIFO whose head entry is readable in the same cycle.
// A push is visible at the head on the cycle after it is written.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/noc_net_iface.sv
// Mesh edge network interface: packetizes local words into HEAD/BODY/TAIL flits
// and strips HEAD flits from ejected traffic for the local consumer.
module noc_net_iface
    import noc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    noc_net_iface_if.slave bus
);
    localparam int ENTRY_W = DATA_W + 1 + X_W + Y_W;

    logic               push, pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               first_q, first_d;
    logic [X_W-1:0]     dst_x_q, dst_x_d, head_dst_x;
    logic [Y_W-1:0]     dst_y_q, dst_y_d, head_dst_y;
    logic [DATA_W-1:0]  head_data;
    logic               head_last;
    logic [DATA_W+1:0]  out_flit;
    head_t              tx_head;
    tx_state_e          tx_state_q, tx_state_d;

    assign push         = bus.tx_valid && !fifo_full;
    assign bus.tx_ready = !fifo_full;

    // Only the first word of a packet supplies dst; later words reuse the held copy.
    always_comb begin
        first_d = first_q;
        dst_x_d = dst_x_q;
        dst_y_d = dst_y_q;
        if (push) begin
            first_d = bus.tx_last;
            if (first_q) begin
                dst_x_d = bus.tx_dst_x;
                dst_y_d = bus.tx_dst_y;
            end
        end
    end

    assign push_entry = {bus.tx_data, bus.tx_last, dst_x_d, dst_y_d};
    assign {head_data, head_last, head_dst_x, head_dst_y} = head_entry;

    noc_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The HEAD flit is built from the FIFO head without popping it.
    always_comb begin
        tx_state_d = tx_state_q;
        pop        = 1'b0;
        tx_head    = '{src_y: DEF_Y_W'(MY_Y), src_x: DEF_X_W'(MY_X),
                       dst_y: head_dst_y,     dst_x: head_dst_x};
        out_flit   = {FLIT_HEAD, pack_head(tx_head)};
        if (tx_state_q == T_BODY)
            out_flit = {(head_last ? FLIT_TAIL : FLIT_BODY), head_data};
        if (!fifo_empty && bus.out_ready) begin
            if (tx_state_q == T_IDLE) begin
                tx_state_d = T_BODY;
            end else begin
                pop = 1'b1;
                if (head_last) tx_state_d = T_IDLE;
            end
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_flit  = out_flit;

    rx_state_e         rx_state_q, rx_state_d;
    flit_type_e        in_type;
    head_t             in_head;
    logic              in_ready, in_hs, err_inc;
    logic              rx_valid_q, rx_valid_d, rx_last_q, rx_last_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [X_W-1:0]    rx_src_x_q, rx_src_x_d;
    logic [Y_W-1:0]    rx_src_y_q, rx_src_y_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign in_type  = flit_type_e'(bus.in_flit[DATA_W+1:DATA_W]);
    assign in_head  = unpack_head(bus.in_flit[DATA_W-1:0]);
    assign in_ready = (rx_state_q == R_HEAD) || !rx_valid_q || bus.rx_ready;
    assign in_hs    = bus.in_valid && in_ready;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_last_d  = rx_last_q;
        rx_src_x_d = rx_src_x_q;
        rx_src_y_d = rx_src_y_q;
        err_inc    = 1'b0;
        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        if (in_hs) begin
            if (rx_state_q == R_HEAD) begin
                if (in_type == FLIT_HEAD) begin
                    rx_src_x_d = in_head.src_x;
                    rx_src_y_d = in_head.src_y;
                    rx_state_d = R_PAY;
                end else begin
                    err_inc = 1'b1;
                end
            end else begin
                case (in_type)
                    FLIT_BODY, FLIT_TAIL: begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = bus.in_flit[DATA_W-1:0];
                        rx_last_d  = (in_type == FLIT_TAIL);
                        if (in_type == FLIT_TAIL) rx_state_d = R_HEAD;
                    end
                    // A stray HEAD abandons the open packet and starts a new one.
                    FLIT_HEAD: begin
                        err_inc    = 1'b1;
                        rx_src_x_d = in_head.src_x;
                        rx_src_y_d = in_head.src_y;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
        end
        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q    <= 1'b1;
            dst_x_q    <= '0;
            dst_y_q    <= '0;
            tx_state_q <= T_IDLE;
            rx_state_q <= R_HEAD;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_src_x_q <= '0;
            rx_src_y_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            first_q    <= first_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            rx_valid_q <= rx_valid_d;
            rx_last_q  <= rx_last_d;
            rx_data_q  <= rx_data_d;
            rx_src_x_q <= rx_src_x_d;
            rx_src_y_q <= rx_src_y_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_last  = rx_last_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_src_x = rx_src_x_q;
    assign bus.rx_src_y = rx_src_y_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed bench for noc_net_iface: TX framing and backpressure, RX
// depacketizing, protocol errors and mid-packet reset.
module tb_noc_net_iface;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   push_edge;

    logic [33:0] out_q[$];
    int          out_edge[$];
    logic [32:0] rx_q[$];
    logic [2:0]  rx_src_q[$];

    noc_net_iface_if #(.DATA_W(32), .X_W(2), .Y_W(1)) bus ();

    noc_net_iface #(
        .DATA_W(32), .X_W(2), .Y_W(1), .MY_X(0), .MY_Y(0), .FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each handshake seen at a falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            out_q.push_back(bus.out_flit);
            out_edge.push_back(cyc + 1);
            $display("tx flit %h at edge %0d", bus.out_flit, cyc + 1);
        end
        if (rst && bus.rx_valid && bus.rx_ready) begin
            rx_q.push_back({bus.rx_last, bus.rx_data});
            rx_src_q.push_back({bus.rx_src_x, bus.rx_src_y});
            $display("rx word %h last=%0d src=(%0d,%0d)", bus.rx_data, bus.rx_last,
                     bus.rx_src_x, bus.rx_src_y);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic send_word(input logic [31:0] d, input logic [1:0] x, input logic y,
                             input logic l);
        int n;
        n = 0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        bus.tx_dst_x = x;
        bus.tx_dst_y = y;
        bus.tx_last  = l;
        @(negedge clk);
        while (!bus.tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("tx_push_timeout", 64'(n), 64'(0));
        push_edge = cyc + 1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic send_flit(input logic [1:0] t, input logic [31:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_flit  = {t, p};
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_flit_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int cnt);
        int k;
        k = 0;
        while (out_q.size() < cnt && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("tx_flit_count", 64'(out_q.size()), 64'(cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int cnt);
        int k;
        k = 0;
        while (rx_q.size() < cnt && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rx_word_count", 64'(rx_q.size()), 64'(cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_ready"},  64'(bus.tx_ready),  64'(1));
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'(1));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_rx_valid"},  64'(bus.rx_valid),  64'(0));
        chk({tag, "_rx_last"},   64'(bus.rx_last),   64'(0));
        chk({tag, "_rx_data"},   64'(bus.rx_data),   64'(0));
        chk({tag, "_rx_src"},    64'({bus.rx_src_x, bus.rx_src_y}), 64'(0));
        chk({tag, "_err_cnt"},   64'(bus.err_cnt),   64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] exp_tx[6];
        logic [32:0] exp_rx[2];
        int p;

        cyc = 0; total = 0; bad = 0; push_edge = 0;
        rst = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_dst_x = '0; bus.tx_dst_y = '0;
        bus.tx_last = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        bus.in_flit = '0; bus.rx_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;

        // 3-word packet to (2,0); dst on later words must be ignored.
        bus.out_ready = 1'b1;
        send_word(32'h11, 2'd2, 1'b0, 1'b0);
        p = push_edge;
        send_word(32'h22, 2'd3, 1'b1, 1'b0);
        send_word(32'h33, 2'd3, 1'b1, 1'b1);
        wait_out(4);
        exp_tx[0] = {2'b01, 32'h0000_0002};
        exp_tx[1] = {2'b10, 32'h0000_0011};
        exp_tx[2] = {2'b10, 32'h0000_0022};
        exp_tx[3] = {2'b11, 32'h0000_0033};
        for (int i = 0; i < 4; i++) begin
            if (i < out_q.size()) begin
                chk($sformatf("t1_flit%0d", i), 64'(out_q[i]), 64'(exp_tx[i]));
                chk($sformatf("t1_edge%0d", i), 64'(out_edge[i]), 64'(p + 1 + i));
            end
        end

        // Backpressure: 5 words offered with out_ready low.
        out_q.delete(); out_edge.delete();
        bus.out_ready = 1'b0;
        send_word(32'h100, 2'd1, 1'b0, 1'b0);
        send_word(32'h101, 2'd2, 1'b1, 1'b0);
        send_word(32'h102, 2'd2, 1'b1, 1'b0);
        send_word(32'h103, 2'd2, 1'b1, 1'b0);
        bus.tx_valid = 1'b1; bus.tx_data = 32'h104; bus.tx_last = 1'b1;
        @(negedge clk);
        chk("t2_tx_ready_full", 64'(bus.tx_ready), 64'(0));
        chk("t2_out_valid", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_head_hold%0d", i), 64'(bus.out_flit), 64'({2'b01, 32'h1}));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.tx_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t2_fifth_push_wait", 64'(n < 50), 64'(1));
            @(posedge clk);
            #1 bus.tx_valid = 1'b0;
        end
        wait_out(6);
        exp_tx[0] = {2'b01, 32'h1};
        exp_tx[1] = {2'b10, 32'h100};
        exp_tx[2] = {2'b10, 32'h101};
        exp_tx[3] = {2'b10, 32'h102};
        exp_tx[4] = {2'b10, 32'h103};
        exp_tx[5] = {2'b11, 32'h104};
        for (int i = 0; i < 6; i++)
            if (i < out_q.size())
                chk($sformatf("t2_flit%0d", i), 64'(out_q[i]), 64'(exp_tx[i]));

        // RX: HEAD src (1,0), BODY 0xA, TAIL 0xB.
        rx_q.delete(); rx_src_q.delete();
        bus.rx_ready = 1'b1;
        send_flit(2'b01, 32'h08);
        send_flit(2'b10, 32'hA);
        send_flit(2'b11, 32'hB);
        wait_rx(2);
        exp_rx[0] = {1'b0, 32'hA};
        exp_rx[1] = {1'b1, 32'hB};
        for (int i = 0; i < 2; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("t3_word%0d", i), 64'(rx_q[i]), 64'(exp_rx[i]));
                chk($sformatf("t3_src%0d", i), 64'(rx_src_q[i]), 64'(3'b010));
            end
        end
        chk("t3_err_cnt", 64'(bus.err_cnt), 64'(0));

        // RX backpressure: rx_ready low during payload.
        rx_q.delete(); rx_src_q.delete();
        bus.rx_ready = 1'b0;
        send_flit(2'b01, 32'h10);
        send_flit(2'b10, 32'h5);
        fork
            send_flit(2'b11, 32'h6);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("t4_in_ready%0d", i), 64'(bus.in_ready), 64'(0));
                    chk($sformatf("t4_hold_data%0d", i), 64'(bus.rx_data), 64'(32'h5));
                    chk($sformatf("t4_hold_valid%0d", i), 64'(bus.rx_valid), 64'(1));
                end
                @(posedge clk);
                #1 bus.rx_ready = 1'b1;
            end
        join
        wait_rx(2);
        exp_rx[0] = {1'b0, 32'h5};
        exp_rx[1] = {1'b1, 32'h6};
        for (int i = 0; i < 2; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("t4_word%0d", i), 64'(rx_q[i]), 64'(exp_rx[i]));
                chk($sformatf("t4_src%0d", i), 64'(rx_src_q[i]), 64'(3'b100));
            end
        end

        // Protocol errors: BODY while idle, then HEAD, HEAD, TAIL.
        rx_q.delete(); rx_src_q.delete();
        send_flit(2'b10, 32'h1);
        send_flit(2'b01, 32'h08);
        send_flit(2'b01, 32'h18);
        send_flit(2'b11, 32'h7);
        wait_rx(1);
        chk("t5_err_cnt", 64'(bus.err_cnt), 64'(2));
        if (rx_q.size() > 0) begin
            chk("t5_word", 64'(rx_q[0]), 64'({1'b1, 32'h7}));
            chk("t5_src", 64'(rx_src_q[0]), 64'(3'b110));
        end

        // Reset with both paths holding partial packets.
        bus.out_ready = 1'b0;
        bus.rx_ready  = 1'b0;
        send_word(32'h200, 2'd2, 1'b0, 1'b0);
        send_word(32'h201, 2'd2, 1'b0, 1'b0);
        send_flit(2'b01, 32'h10);
        send_flit(2'b10, 32'h3);
        @(negedge clk);
        chk("t6_pre_rx_valid", 64'(bus.rx_valid), 64'(1));
        chk("t6_pre_out_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("t6_async");
        @(posedge clk);
        #1 rst = 1'b1;
        out_q.delete(); out_edge.delete(); rx_q.delete(); rx_src_q.delete();

        bus.out_ready = 1'b1;
        bus.rx_ready  = 1'b1;
        send_word(32'h55, 2'd1, 1'b0, 1'b1);
        wait_out(2);
        if (out_q.size() >= 2) begin
            chk("t6_head", 64'(out_q[0]), 64'({2'b01, 32'h1}));
            chk("t6_tail", 64'(out_q[1]), 64'({2'b11, 32'h55}));
        end
        send_flit(2'b01, 32'h28);
        send_flit(2'b11, 32'h9);
        wait_rx(1);
        if (rx_q.size() > 0) begin
            chk("t6_rx_word", 64'(rx_q[0]), 64'({1'b1, 32'h9}));
            chk("t6_rx_src", 64'(rx_src_q[0]), 64'(3'b011));
        end
        chk("t6_err_cnt", 64'(bus.err_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
